// File: rtl/ctrl_io_dr_switch_matrix_seq.sv
// Dual-rail east->west switch matrix with serial config chain, glitch-free shadow commit,
// precharge/evaluate phasing and A_Q0 completion / illegal-codeword / timeout monitoring.
module ctrl_io_dr_switch_matrix_seq #(
  parameter int N_CH    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            resetn,
  input  logic            cfg_shift_en,
  input  logic            cfg_din,
  output logic            cfg_dout,
  input  logic            cfg_commit,
  output logic            cfg_pending,
  input  logic            eval,
  input  logic [N_CH-1:0] from_E_t,
  input  logic [N_CH-1:0] from_E_f,
  output logic [N_CH-1:0] to_W_t,
  output logic [N_CH-1:0] to_W_f,
  input  logic            A_Q0_t,
  input  logic            A_Q0_f,
  output logic            A_I0_t,
  output logic            A_I0_f,
  output logic            A_T,
  output logic            q_valid,
  output logic            err_illegal,
  output logic            err_timeout,
  input  logic            err_clr,
  output logic [1:0]      phase
);
  localparam int SEL_W = $clog2(N_CH);
  localparam int CFG_W = N_CH + SEL_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {PRE = 2'd0, EVAL = 2'd1, DONE = 2'd2, TMO = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CFG_W-1:0] shift_reg, stage_reg, active_cfg;
  logic             pending;
  logic             q_ok, q_ill, cnt_last, can_apply, gate;
  logic [N_CH-1:0]  wsel;
  logic [SEL_W-1:0] isel;
  logic             sel_t, sel_f;

  assign q_ok      = A_Q0_t ^ A_Q0_f;
  assign q_ill     = A_Q0_t & A_Q0_f;
  assign cnt_last  = (cnt == CNT_W'(TIMEOUT - 1));
  assign can_apply = (state == PRE) && !eval;

  assign wsel        = active_cfg[N_CH-1:0];
  assign isel        = active_cfg[N_CH+SEL_W-1:N_CH];
  assign A_T         = active_cfg[CFG_W-1];
  assign cfg_dout    = shift_reg[CFG_W-1];
  assign cfg_pending = pending;

  // A commit seen while already in a quiet precharge cycle goes straight to the active copy.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      shift_reg  <= '0;
      stage_reg  <= '0;
      active_cfg <= '0;
      pending    <= 1'b0;
    end else begin
      if (cfg_shift_en) shift_reg <= {shift_reg[CFG_W-2:0], cfg_din};
      if (cfg_commit && can_apply) begin
        active_cfg <= shift_reg;
        pending    <= 1'b0;
      end else if (cfg_commit) begin
        stage_reg <= shift_reg;
        pending   <= 1'b1;
      end else if (pending && can_apply) begin
        active_cfg <= stage_reg;
        pending    <= 1'b0;
      end
    end
  end

  // FSM state register; cnt counts completed EVAL cycles
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state <= PRE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == EVAL && state_nxt == EVAL) cnt <= cnt + 1'b1;
      else cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!eval) begin
      state_nxt = PRE;
    end else begin
      case (state)
        PRE:  state_nxt = EVAL;
        EVAL: begin
          if (q_ok) state_nxt = DONE;
          else if (cnt_last) state_nxt = TMO;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    gate  = (state != PRE);
    phase = state;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      q_valid     <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      q_valid     <= (state == EVAL) && (state_nxt == DONE);
      err_timeout <= ((state == EVAL) && (state_nxt == TMO)) | (err_timeout & ~err_clr);
      err_illegal <= q_ill | (err_illegal & ~err_clr);
    end
  end

  // Both rails share one select so A_I0 never shows a mixed codeword.
  always_comb begin
    sel_t = 1'b0;
    sel_f = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (isel == SEL_W'(i)) begin
        sel_t = from_E_t[i];
        sel_f = from_E_f[i];
      end
    end
    to_W_t = {N_CH{gate}} & ((from_E_t & ~wsel) | (wsel & {N_CH{A_Q0_t}}));
    to_W_f = {N_CH{gate}} & ((from_E_f & ~wsel) | (wsel & {N_CH{A_Q0_f}}));
    A_I0_t = gate & sel_t;
    A_I0_f = gate & sel_f;
  end
endmodule

// File: tb/tb_ctrl_io_dr_switch_matrix_seq.sv
// Bench for ctrl_io_dr_switch_matrix_seq: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural model of config, phasing and error flags.
module tb_ctrl_io_dr_switch_matrix_seq;
  localparam int N_CH    = 8;
  localparam int TIMEOUT = 16;
  localparam int SEL_W   = $clog2(N_CH);
  localparam int CFG_W   = N_CH + SEL_W + 1;
  localparam logic [1:0] PH_PRE = 2'd0, PH_EVAL = 2'd1, PH_DONE = 2'd2, PH_TMO = 2'd3;

  logic            CLK, resetn, cfg_shift_en, cfg_din, cfg_dout, cfg_commit, cfg_pending, eval;
  logic [N_CH-1:0] from_E_t, from_E_f, to_W_t, to_W_f;
  logic            A_Q0_t, A_Q0_f, A_I0_t, A_I0_f, A_T;
  logic            q_valid, err_illegal, err_timeout, err_clr;
  logic [1:0]      phase;
  int              n_checks, n_errors;

  ctrl_io_dr_switch_matrix_seq #(.N_CH(N_CH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .resetn(resetn), .cfg_shift_en(cfg_shift_en), .cfg_din(cfg_din),
    .cfg_dout(cfg_dout), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .eval(eval),
    .from_E_t(from_E_t), .from_E_f(from_E_f), .to_W_t(to_W_t), .to_W_f(to_W_f),
    .A_Q0_t(A_Q0_t), .A_Q0_f(A_Q0_f), .A_I0_t(A_I0_t), .A_I0_f(A_I0_f), .A_T(A_T),
    .q_valid(q_valid), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .err_clr(err_clr), .phase(phase)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // behavioural model
  logic [CFG_W-1:0] m_shift, m_stage, m_active;
  logic             m_pending, m_qv, m_eill, m_etmo;
  logic [1:0]       m_phase;
  int               m_age;

  always @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      m_shift <= '0; m_stage <= '0; m_active <= '0; m_pending <= 1'b0;
      m_phase <= PH_PRE; m_age <= 0; m_qv <= 1'b0; m_eill <= 1'b0; m_etmo <= 1'b0;
    end else begin
      if (cfg_shift_en) m_shift <= {m_shift[CFG_W-2:0], cfg_din};
      if (m_phase == PH_PRE && !eval) begin
        if (cfg_commit) m_active <= m_shift;
        else if (m_pending) m_active <= m_stage;
        m_pending <= 1'b0;
      end else if (cfg_commit) begin
        m_stage <= m_shift;
        m_pending <= 1'b1;
      end
      m_qv <= 1'b0;
      if (!eval) m_phase <= PH_PRE;
      else if (m_phase == PH_PRE) begin
        m_phase <= PH_EVAL;
        m_age <= 1;
      end else if (m_phase == PH_EVAL) begin
        if (A_Q0_t != A_Q0_f) begin
          m_phase <= PH_DONE;
          m_qv <= 1'b1;
        end else if (m_age == TIMEOUT) m_phase <= PH_TMO;
        else m_age <= m_age + 1;
      end
      m_etmo <= (m_phase == PH_EVAL && eval && A_Q0_t == A_Q0_f && m_age == TIMEOUT) || (m_etmo && !err_clr);
      m_eill <= (A_Q0_t && A_Q0_f) || (m_eill && !err_clr);
    end
  end

  function automatic logic [N_CH-1:0] exp_w(input logic [N_CH-1:0] fe, input logic q);
    logic [N_CH-1:0] ws;
    ws = m_active[N_CH-1:0];
    if (m_phase == PH_PRE) return '0;
    return (fe & ~ws) | (ws & {N_CH{q}});
  endfunction

  function automatic logic exp_i(input logic [N_CH-1:0] fe);
    int s;
    s = int'(m_active[N_CH+SEL_W-1:N_CH]);
    if (m_phase == PH_PRE || s >= N_CH) return 1'b0;
    return fe[s];
  endfunction

  // driver tasks
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    cfg_shift_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0; eval = 1'b0;
    from_E_t = '0; from_E_f = '0; A_Q0_t = 1'b0; A_Q0_f = 1'b0; err_clr = 1'b0;
  endtask

  task automatic shift_word(input logic [CFG_W-1:0] w);
    for (int i = CFG_W - 1; i >= 0; i--) begin
      cfg_shift_en = 1'b1;
      cfg_din = w[i];
      step();
    end
    cfg_shift_en = 1'b0;
    cfg_din = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    eval = 1'b1; from_E_t = '1; from_E_f = '1; A_Q0_t = 1'b1; A_Q0_f = 1'b1;
    cfg_shift_en = 1'b1; cfg_din = 1'b1; cfg_commit = 1'b1;
    step(); step(); step();
    n_checks++;
    if ({to_W_t, to_W_f, A_I0_t, A_I0_f, A_T, cfg_dout, cfg_pending, q_valid, err_illegal, err_timeout} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got to_W_t=%0h to_W_f=%0h I0=%b%b A_T=%b dout=%b pend=%b qv=%b ill=%b tmo=%b expected all 0",
               to_W_t, to_W_f, A_I0_t, A_I0_f, A_T, cfg_dout, cfg_pending, q_valid, err_illegal, err_timeout);
    end
    n_checks++;
    if (phase !== PH_PRE) begin n_errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    idle_inputs();
    resetn = 1'b1;
    step();
    n_checks++;
    if (phase !== PH_PRE || A_T !== 1'b0) begin
      n_errors++; $display("FAIL reset_release: got phase=%0d A_T=%b expected 0 0", phase, A_T);
    end
  endtask

  task automatic test_cfg_load();
    logic [CFG_W-1:0] w;
    w = {1'b1, 3'd3, 8'h00};
    shift_word(w);
    n_checks++;
    if (cfg_dout !== 1'b1) begin n_errors++; $display("FAIL cfg_dout_msb: got %b expected 1", cfg_dout); end
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    n_checks++;
    if (A_T !== 1'b1 || cfg_pending !== 1'b0) begin
      n_errors++; $display("FAIL cfg_commit_pre: got A_T=%b pending=%b expected 1 0", A_T, cfg_pending);
    end
  endtask

  task automatic test_route();
    logic [N_CH-1:0] r;
    r = N_CH'($urandom);
    r[3] = 1'b1;
    from_E_t = r; from_E_f = ~r;
    eval = 1'b1;
    step();
    n_checks++;
    if (phase !== PH_EVAL) begin n_errors++; $display("FAIL route_phase: got %0d expected 1", phase); end
    n_checks++;
    if (A_I0_t !== 1'b1 || A_I0_f !== 1'b0) begin
      n_errors++; $display("FAIL route_i0: got %b%b expected 10", A_I0_t, A_I0_f);
    end
    n_checks++;
    if (to_W_t !== r || to_W_f !== ~r) begin
      n_errors++; $display("FAIL route_w: got %0h/%0h expected %0h/%0h", to_W_t, to_W_f, r, ~r);
    end
    eval = 1'b0;
    step();
    n_checks++;
    if ({to_W_t, to_W_f, A_I0_t, A_I0_f} !== '0 || phase !== PH_PRE) begin
      n_errors++; $display("FAIL route_spacer: got w=%0h/%0h I0=%b%b phase=%0d expected 0", to_W_t, to_W_f, A_I0_t, A_I0_f, phase);
    end
  endtask

  task automatic test_done();
    eval = 1'b1; A_Q0_t = 1'b0; A_Q0_f = 1'b0;
    step();
    for (int c = 1; c <= 4; c++) begin
      step();
      n_checks++;
      if (phase !== PH_EVAL || q_valid !== 1'b0) begin
        n_errors++; $display("FAIL done_wait c=%0d: got phase=%0d qv=%b expected 1 0", c, phase, q_valid);
      end
    end
    A_Q0_f = 1'b1;
    step();
    n_checks++;
    if (phase !== PH_DONE || q_valid !== 1'b1) begin
      n_errors++; $display("FAIL done_pulse: got phase=%0d qv=%b expected 2 1", phase, q_valid);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (phase !== PH_DONE || q_valid !== 1'b0) begin
        n_errors++; $display("FAIL done_hold c=%0d: got phase=%0d qv=%b expected 2 0", c, phase, q_valid);
      end
    end
    eval = 1'b0; A_Q0_f = 1'b0;
    step();
    n_checks++;
    if (phase !== PH_PRE) begin n_errors++; $display("FAIL done_exit: got %0d expected 0", phase); end
  endtask

  task automatic test_timeout();
    logic [1:0] ep;
    eval = 1'b1;
    step();
    for (int c = 1; c <= TIMEOUT + 2; c++) begin
      step();
      ep = (c >= TIMEOUT) ? PH_TMO : PH_EVAL;
      n_checks++;
      if (phase !== ep || err_timeout !== (c >= TIMEOUT)) begin
        n_errors++; $display("FAIL timeout c=%0d: got phase=%0d tmo=%b expected %0d %b", c, phase, err_timeout, ep, c >= TIMEOUT);
      end
    end
    eval = 1'b0;
    step();
    n_checks++;
    if (phase !== PH_PRE || err_timeout !== 1'b1) begin
      n_errors++; $display("FAIL timeout_sticky: got phase=%0d tmo=%b expected 0 1", phase, err_timeout);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++;
    if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_clr: got %b expected 0", err_timeout); end
  endtask

  task automatic test_deferred_commit();
    from_E_t = 8'h08; from_E_f = 8'hF7;
    eval = 1'b1;
    step();
    shift_word({1'b0, 3'd1, 8'hA5});
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    n_checks++;
    if (cfg_pending !== 1'b1 || A_T !== 1'b1 || A_I0_t !== 1'b1 || A_I0_f !== 1'b0 || to_W_t !== 8'h08) begin
      n_errors++; $display("FAIL defer_hold: got pend=%b A_T=%b I0=%b%b w=%0h expected 1 1 10 08", cfg_pending, A_T, A_I0_t, A_I0_f, to_W_t);
    end
    eval = 1'b0;
    step();
    n_checks++;
    if (phase !== PH_PRE || to_W_t !== '0) begin
      n_errors++; $display("FAIL defer_pre: got phase=%0d w=%0h expected 0 0", phase, to_W_t);
    end
    step();
    n_checks++;
    if (cfg_pending !== 1'b0 || A_T !== 1'b0) begin
      n_errors++; $display("FAIL defer_apply: got pend=%b A_T=%b expected 0 0", cfg_pending, A_T);
    end
    from_E_t = 8'h3C; from_E_f = 8'hC3; A_Q0_t = 1'b1; A_Q0_f = 1'b0;
    eval = 1'b1;
    step();
    n_checks++;
    if (to_W_t !== 8'hBD || to_W_f !== 8'h42 || A_I0_t !== 1'b0 || A_I0_f !== 1'b1) begin
      n_errors++; $display("FAIL defer_route: got w=%0h/%0h I0=%b%b expected bd/42 01", to_W_t, to_W_f, A_I0_t, A_I0_f);
    end
    eval = 1'b0; A_Q0_t = 1'b0;
    step();
  endtask

  task automatic test_illegal_chain();
    logic [CFG_W-1:0] w;
    A_Q0_t = 1'b1; A_Q0_f = 1'b1; err_clr = 1'b1;
    step();
    n_checks++;
    if (err_illegal !== 1'b1) begin n_errors++; $display("FAIL illegal_set: got %b expected 1", err_illegal); end
    A_Q0_t = 1'b0; A_Q0_f = 1'b0;
    step();
    err_clr = 1'b0;
    n_checks++;
    if (err_illegal !== 1'b0) begin n_errors++; $display("FAIL illegal_clr: got %b expected 0", err_illegal); end
    w = CFG_W'($urandom);
    shift_word(w);
    for (int j = 0; j < CFG_W; j++) begin
      n_checks++;
      if (cfg_dout !== w[CFG_W-1-j]) begin
        n_errors++; $display("FAIL chain_out j=%0d: got %b expected %b", j, cfg_dout, w[CFG_W-1-j]);
      end
      cfg_shift_en = 1'b1;
      cfg_din = 1'($urandom);
      step();
    end
    cfg_shift_en = 1'b0;
  endtask

  task automatic test_async_reset();
    shift_word({1'b1, 3'd0, 8'hFF});
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    shift_word({1'b0, 3'd2, 8'h00});
    from_E_t = 8'hFF; eval = 1'b1;
    step();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    n_checks++;
    if (A_T !== 1'b1 || cfg_pending !== 1'b1 || A_I0_t !== 1'b1) begin
      n_errors++; $display("FAIL areset_pre: got A_T=%b pend=%b I0_t=%b expected 1 1 1", A_T, cfg_pending, A_I0_t);
    end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({to_W_t, to_W_f, A_I0_t, A_I0_f, A_T, cfg_pending, phase} !== '0) begin
      n_errors++; $display("FAIL areset_now: got w=%0h/%0h I0=%b%b A_T=%b pend=%b phase=%0d expected 0",
                           to_W_t, to_W_f, A_I0_t, A_I0_f, A_T, cfg_pending, phase);
    end
    @(negedge CLK);
    idle_inputs();
    resetn = 1'b1;
    step();
    n_checks++;
    if (A_T !== 1'b0 || cfg_pending !== 1'b0 || phase !== PH_PRE) begin
      n_errors++; $display("FAIL areset_after: got A_T=%b pend=%b phase=%0d expected 0 0 0", A_T, cfg_pending, phase);
    end
  endtask

  task automatic test_random();
    int q;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 23) == 0) eval = ~eval;
      cfg_shift_en = 1'($urandom);
      cfg_din = 1'($urandom);
      cfg_commit = ($urandom_range(0, 11) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      from_E_t = N_CH'($urandom);
      from_E_f = N_CH'($urandom);
      q = $urandom_range(0, 19);
      A_Q0_t = (q == 18 || q == 19);
      A_Q0_f = (q == 17 || q == 19);
      #1;
      n_checks++;
      if (phase !== m_phase) begin n_errors++; $display("FAIL rnd_phase c=%0d: got %0d expected %0d", c, phase, m_phase); end
      n_checks++;
      if (to_W_t !== exp_w(from_E_t, A_Q0_t) || to_W_f !== exp_w(from_E_f, A_Q0_f)) begin
        n_errors++; $display("FAIL rnd_w c=%0d: got %0h/%0h expected %0h/%0h", c, to_W_t, to_W_f,
                             exp_w(from_E_t, A_Q0_t), exp_w(from_E_f, A_Q0_f));
      end
      n_checks++;
      if (A_I0_t !== exp_i(from_E_t) || A_I0_f !== exp_i(from_E_f)) begin
        n_errors++; $display("FAIL rnd_i0 c=%0d: got %b%b expected %b%b", c, A_I0_t, A_I0_f, exp_i(from_E_t), exp_i(from_E_f));
      end
      n_checks++;
      if (A_T !== m_active[CFG_W-1] || cfg_pending !== m_pending || cfg_dout !== m_shift[CFG_W-1]) begin
        n_errors++; $display("FAIL rnd_cfg c=%0d: got A_T=%b pend=%b dout=%b expected %b %b %b", c, A_T, cfg_pending,
                             cfg_dout, m_active[CFG_W-1], m_pending, m_shift[CFG_W-1]);
      end
      n_checks++;
      if (q_valid !== m_qv || err_illegal !== m_eill || err_timeout !== m_etmo) begin
        n_errors++; $display("FAIL rnd_flags c=%0d: got qv=%b ill=%b tmo=%b expected %b %b %b", c, q_valid, err_illegal,
                             err_timeout, m_qv, m_eill, m_etmo);
      end
      @(posedge CLK);
      @(negedge CLK);
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    @(negedge CLK);
    test_reset();
    test_cfg_load();
    test_route();
    test_done();
    test_timeout();
    test_deferred_commit();
    test_illegal_chain();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
